dcmac_0_axis_pkt_gen_dat_pack: RTL and testbench
================================================

DCMAC_0_AXIS_PKT_GEN_DAT_PACK -- requirements
Module: dcmac_0_axis_pkt_gen_dat_pack

Interface
REQ-001 SHALL have parameter NUM_ID, default 6: number of independent channel IDs; ID_W = (NUM_ID==1) ? 1 : clog2(NUM_ID).
REQ-002 SHALL have parameter DW_BYTES, default 192: output word width in bytes, legal range >= 2; CNT_W = clog2(DW_BYTES+1).
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_vld  input  1  input beat valid.
REQ-006 o_rdy  output  1  input beat ready.
REQ-007 i_id  input  ID_W  channel of the input beat.
REQ-008 i_nbytes  input  CNT_W  number of valid bytes in i_dat, range 0..DW_BYTES, LSB-aligned.
REQ-009 i_flush  input  1  emit the channel's packed bytes even if the word is short.
REQ-010 i_dat  input  DW_BYTES*8  data; byte 0 = i_dat[7:0] = first in stream order.
REQ-011 o_vld  output  1  output word valid.
REQ-012 i_rdy  input  1  downstream ready.
REQ-013 o_id  output  ID_W  channel of the output word.
REQ-014 o_nbytes  output  CNT_W  valid bytes in o_dat, 1..DW_BYTES.
REQ-015 o_dat  output  DW_BYTES*8  packed data, LSB-aligned.
REQ-016 o_err  output  1  one-cycle pulse: illegal beat dropped.

Function
REQ-017 SHALL keep per-ID residual state: cnt[k] (0..DW_BYTES-1) and res[k] (DW_BYTES-1 bytes); accept = i_vld & o_rdy; o_rdy = ~o_vld | i_rdy.
REQ-018 On a legal accepted beat, with r = cnt[i_id], n = i_nbytes, t = r+n, merged byte j SHALL be res[j] for j<r, else i_dat[j-r], for j<t.
REQ-019 If t >= DW_BYTES: SHALL emit merged bytes 0..DW_BYTES-1 with o_nbytes=DW_BYTES, then set cnt=t-DW_BYTES and res = i_dat bytes DW_BYTES-r..n-1 (relocated to start at byte 0).
REQ-020 If t < DW_BYTES and i_flush=1 and t>0: SHALL emit merged bytes with o_nbytes=t and set cnt=0; if t=0 no word SHALL be emitted.
REQ-021 If t < DW_BYTES and i_flush=0: SHALL emit nothing and set res=merged, cnt=t.
REQ-022 If t > DW_BYTES and i_flush=1: SHALL emit the full word only; remainder retained per REQ-019, flush NOT completed (caller reissues).
REQ-023 Bytes of o_dat at index >= o_nbytes SHALL be zero.
REQ-024 Latency SHALL be exactly 1 cycle: outputs registered on the accepting edge; per-ID state updated on the same edge, so back-to-back beats on the same ID SHALL merge correctly with no bubble.
REQ-025 While o_vld=1 and i_rdy=0, o_vld/o_id/o_nbytes/o_dat SHALL hold stable and no beat SHALL be accepted.
REQ-026 o_vld SHALL deassert on the edge after handshake when no new word is produced.
REQ-027 Illegal beat (i_id >= NUM_ID, i_nbytes > DW_BYTES, or i_nbytes=0 with i_flush=0): SHALL be accepted and dropped, o_err=1 for one cycle, no state change, no output word.
REQ-028 Beats on other IDs SHALL never alter cnt/res of a given ID.

Reset
REQ-029 rst_n=0 SHALL asynchronously force cnt[all]=0, o_vld=0, o_id=0, o_nbytes=0, o_dat=0, o_err=0; res storage need not be reset.
REQ-030 Reset mid-stream SHALL discard all residual bytes and any unaccepted output word; first beat after release SHALL see r=0.
REQ-031 o_rdy SHALL be 1 while o_vld=0, including during and after reset.

Verification (NUM_ID=4, DW_BYTES=8 unless stated)
REQ-032 id0 n=5 bytes 00..04, then id0 n=5 bytes 05..09 -> no word for first; next cycle o_vld, o_id=0, o_dat=00..07, o_nbytes=8; cnt[0]=2.
REQ-033 Then id1 n=3 (A0..A2), id2 n=8 (B0..B7) back-to-back -> only id2 emits B0..B7, nbytes 8; then id0 n=0 flush -> o_dat=08,09,0,..., o_nbytes=2; id1 cnt still 3.
REQ-034 o_vld=1 with i_rdy=0 for 3 cycles while i_vld=1 -> o_rdy=0, outputs unchanged, no beat lost; after i_rdy=1 all words appear in order.
REQ-035 i_nbytes=9, then i_id=5 with NUM_ID=4 replaced by NUM_ID=6 i_id=6 -> o_err pulses each, no o_vld, cnt unchanged.
REQ-036 cnt[0]=5, rst_n low 2 cycles mid-stream -> after release, id0 n=3 emits nothing, then id0 n=5 emits 8 bytes with first 3 = new beat's bytes.
REQ-037 Default parameters (NUM_ID=6, DW_BYTES=192): random legal traffic, byte-stream per ID matches reference model exactly.

Source files
------------

// File: rtl/dcmac_0_axis_pkt_gen_dat_pack_if.sv
// rtl/dcmac_0_axis_pkt_gen_dat_pack_if.sv - beat-in / word-out bus of the per-ID byte packer
interface dcmac_0_axis_pkt_gen_dat_pack_if #(
  parameter int NUM_ID   = 6,
  parameter int DW_BYTES = 192
);
  localparam int ID_W  = (NUM_ID == 1) ? 1 : $clog2(NUM_ID);
  localparam int CNT_W = $clog2(DW_BYTES + 1);

  logic                  i_vld;
  logic                  o_rdy;
  logic [ID_W-1:0]       i_id;
  logic [CNT_W-1:0]      i_nbytes;
  logic                  i_flush;
  logic [DW_BYTES*8-1:0] i_dat;
  logic                  o_vld;
  logic                  i_rdy;
  logic [ID_W-1:0]       o_id;
  logic [CNT_W-1:0]      o_nbytes;
  logic [DW_BYTES*8-1:0] o_dat;
  logic                  o_err;

  modport master (
    output i_vld, i_id, i_nbytes, i_flush, i_dat, i_rdy,
    input  o_rdy, o_vld, o_id, o_nbytes, o_dat, o_err
  );

  modport slave (
    input  i_vld, i_id, i_nbytes, i_flush, i_dat, i_rdy,
    output o_rdy, o_vld, o_id, o_nbytes, o_dat, o_err
  );
endinterface

// File: rtl/dcmac_0_axis_pkt_gen_dat_pack.sv
// rtl/dcmac_0_axis_pkt_gen_dat_pack.sv - packs variable-length beats into full words per channel ID
module dcmac_0_axis_pkt_gen_dat_pack #(
  parameter int NUM_ID   = 6,
  parameter int DW_BYTES = 192
) (
  input logic clk,
  input logic rst_n,
  dcmac_0_axis_pkt_gen_dat_pack_if.slave bus
);
  localparam int ID_W  = (NUM_ID == 1) ? 1 : $clog2(NUM_ID);
  localparam int CNT_W = $clog2(DW_BYTES + 1);
  localparam int W     = DW_BYTES * 8;
  localparam int RW    = (DW_BYTES - 1) * 8;
  localparam int MW    = W + RW;

  logic [CNT_W-1:0] cnt [NUM_ID];
  logic [RW-1:0]    res [NUM_ID];

  logic             accept;
  logic             id_ok;
  logic             legal;
  logic             full;
  logic             emit;
  logic [ID_W-1:0]  idx;
  logic [CNT_W-1:0] r;
  logic [CNT_W:0]   t;
  logic [W-1:0]     dat_m;
  logic [RW-1:0]    res_m;
  logic [MW-1:0]    merged;
  logic [CNT_W-1:0] cnt_nxt;
  logic [RW-1:0]    res_nxt;

  assign bus.o_rdy = ~bus.o_vld | bus.i_rdy;
  assign accept    = bus.i_vld & bus.o_rdy;
  assign id_ok     = {1'b0, bus.i_id} < (ID_W + 1)'(NUM_ID);
  assign legal     = id_ok && (bus.i_nbytes <= CNT_W'(DW_BYTES)) &&
                     (bus.i_flush || (bus.i_nbytes != '0));
  assign idx       = id_ok ? bus.i_id : '0;
  assign r         = cnt[idx];
  assign t         = {1'b0, r} + {1'b0, bus.i_nbytes};
  assign full      = t >= (CNT_W + 1)'(DW_BYTES);
  assign emit      = full | (bus.i_flush & (t != '0));

  // Bytes past the valid count are zeroed so the merge can be a plain OR.
  always_comb begin
    dat_m = '0;
    res_m = '0;
    for (int j = 0; j < DW_BYTES; j++) begin
      if (CNT_W'(j) < bus.i_nbytes) dat_m[j*8 +: 8] = bus.i_dat[j*8 +: 8];
    end
    for (int j = 0; j < DW_BYTES - 1; j++) begin
      if (CNT_W'(j) < r) res_m[j*8 +: 8] = res[idx][j*8 +: 8];
    end
  end

  assign merged  = MW'(res_m) | (MW'(dat_m) << {r, 3'b000});
  assign cnt_nxt = full ? CNT_W'(t - (CNT_W + 1)'(DW_BYTES)) :
                   (bus.i_flush ? '0 : t[CNT_W-1:0]);
  assign res_nxt = full ? merged[MW-1:W] : merged[RW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ID; k++) cnt[k] <= '0;
      bus.o_vld    <= 1'b0;
      bus.o_id     <= '0;
      bus.o_nbytes <= '0;
      bus.o_dat    <= '0;
      bus.o_err    <= 1'b0;
    end else begin
      bus.o_err <= accept & ~legal;
      if (bus.o_rdy) bus.o_vld <= 1'b0;
      if (accept && legal) begin
        cnt[idx] <= cnt_nxt;
        if (emit) begin
          bus.o_vld    <= 1'b1;
          bus.o_id     <= bus.i_id;
          bus.o_nbytes <= full ? CNT_W'(DW_BYTES) : t[CNT_W-1:0];
          bus.o_dat    <= merged[W-1:0];
        end
      end
    end
  end

  // Residual bytes are only meaningful below cnt, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept && legal) res[idx] <= res_nxt;
  end
endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_dat_pack.sv
// tb/tb_dcmac_0_axis_pkt_gen_dat_pack.sv - bench for the per-ID byte packer, small and default sizes
module tb_dcmac_0_axis_pkt_gen_dat_pack;
  typedef struct {
    logic [2:0]    id;
    int            nb;
    logic [1535:0] dat;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic phase = 1'b0;
  logic vld = 1'b0;
  logic i_rdy = 1'b1;
  logic rdy_rand = 1'b0;
  logic [2:0] b_id = '0;
  logic [7:0] b_nb = '0;
  logic b_fl = 1'b0;
  logic [1535:0] b_dat = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] bq [6][$];
  word_t exp_q [$];
  logic err_sched = 1'b0;
  logic err_cur = 1'b0;

  logic          prev_hold = 1'b0;
  logic [2:0]    h_id;
  logic [7:0]    h_nb;
  logic [1535:0] h_dat;

  always #5 clk = ~clk;

  dcmac_0_axis_pkt_gen_dat_pack_if #(.NUM_ID(6), .DW_BYTES(8))   ifs ();
  dcmac_0_axis_pkt_gen_dat_pack_if #(.NUM_ID(6), .DW_BYTES(192)) ifl ();

  dcmac_0_axis_pkt_gen_dat_pack #(.NUM_ID(6), .DW_BYTES(8))   dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));
  dcmac_0_axis_pkt_gen_dat_pack #(.NUM_ID(6), .DW_BYTES(192)) dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl.slave));

  assign ifs.i_vld    = vld & ~phase;
  assign ifs.i_id     = b_id;
  assign ifs.i_nbytes = b_nb[3:0];
  assign ifs.i_flush  = b_fl;
  assign ifs.i_dat    = b_dat[63:0];
  assign ifs.i_rdy    = i_rdy;
  assign ifl.i_vld    = vld & phase;
  assign ifl.i_id     = b_id;
  assign ifl.i_nbytes = b_nb;
  assign ifl.i_flush  = b_fl;
  assign ifl.i_dat    = b_dat;
  assign ifl.i_rdy    = i_rdy;

  logic          m_vld, m_rdy, m_err;
  logic [2:0]    m_id;
  logic [7:0]    m_nb;
  logic [1535:0] m_dat;
  assign m_vld = phase ? ifl.o_vld : ifs.o_vld;
  assign m_rdy = phase ? ifl.o_rdy : ifs.o_rdy;
  assign m_err = phase ? ifl.o_err : ifs.o_err;
  assign m_id  = phase ? ifl.o_id : ifs.o_id;
  assign m_nb  = phase ? ifl.o_nbytes : {4'b0, ifs.o_nbytes};
  assign m_dat = phase ? ifl.o_dat : {1472'b0, ifs.o_dat};

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [1535:0] act, input logic [1535:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int j = 0; j < 192; j++) begin
        if (act[j*8 +: 8] !== exp[j*8 +: 8]) begin
          $display("FAIL %s: byte %0d got %0h, want %0h (low word got %0h want %0h)",
                   nm, j, act[j*8 +: 8], exp[j*8 +: 8], act[63:0], exp[63:0]);
          break;
        end
      end
    end
  endtask

  // Reference: a byte FIFO per ID; a word leaves once a full word is queued or on flush.
  task automatic model(input logic [2:0] id, input int n, input logic fl, input logic [1535:0] d);
    int dw;
    word_t w;
    dw = phase ? 192 : 8;
    if (id >= 3'd6 || n > dw || (n == 0 && !fl)) begin
      err_sched = 1'b1;
      return;
    end
    for (int j = 0; j < n; j++) bq[id].push_back(d[j*8 +: 8]);
    if (bq[id].size() >= dw || (fl && bq[id].size() > 0)) begin
      w.id  = id;
      w.dat = '0;
      w.nb  = (bq[id].size() >= dw) ? dw : bq[id].size();
      for (int j = 0; j < w.nb; j++) w.dat[j*8 +: 8] = bq[id].pop_front();
      exp_q.push_back(w);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) bq[k].delete();
    exp_q.delete();
    err_sched = 1'b0;
  endtask

  task automatic send(input logic [2:0] id, input int n, input logic fl, input logic [1535:0] d);
    int g;
    @(negedge clk);
    vld = 1'b1; b_id = id; b_nb = 8'(n); b_fl = fl; b_dat = d;
    #1;
    g = 0;
    while (!m_rdy && g < 1000) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!m_rdy) chk("send_timeout", 1, 0);
    else model(id, n, fl, d);
  endtask

  task automatic idle();
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_vld) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rdy_rand) i_rdy = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    word_t w;
    #2;
    if (!rst_n) begin
      prev_hold = 1'b0;
      err_cur   = 1'b0;
    end else begin
      chk("o_err", m_err, err_cur);
      err_cur   = err_sched;
      err_sched = 1'b0;
      chk("o_rdy", m_rdy, !m_vld || i_rdy);
      if (prev_hold) begin
        chk("hold_vld", m_vld, 1);
        chk("hold_id", m_id, h_id);
        chk("hold_nb", m_nb, h_nb);
        chk_dat("hold_dat", m_dat, h_dat);
      end
      prev_hold = 1'b0;
      if (m_vld) begin
        if (i_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            w = exp_q.pop_front();
            chk("word_id", m_id, w.id);
            chk("word_nb", m_nb, w.nb);
            chk_dat("word_dat", m_dat, w.dat);
          end
        end else begin
          prev_hold = 1'b1;
          h_id = m_id; h_nb = m_nb; h_dat = m_dat;
        end
      end
    end
  end

  initial begin
    logic [1535:0] d;
    int n;
    logic fl;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_vld", m_vld, 0);
    chk("rst_rdy", m_rdy, 1);
    chk("rst_err", m_err, 0);
    chk("rst_nb", m_nb, 0);
    chk_dat("rst_dat", m_dat, '0);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'd0, 5, 1'b0, 1536'h0403020100);
    idle(); #2;
    chk("first_no_word", m_vld, 0);
    send(3'd0, 5, 1'b0, 1536'h0908070605);
    idle(); #2;
    chk("w0_vld", m_vld, 1);
    chk("w0_id", m_id, 0);
    chk("w0_nb", m_nb, 8);
    chk_dat("w0_dat", m_dat, 1536'h0706050403020100);

    send(3'd1, 3, 1'b0, 1536'hEEEE_EEEE_EEA2A1A0);
    send(3'd2, 8, 1'b0, 1536'hB7B6B5B4B3B2B1B0);
    idle(); #2;
    chk("w2_id", m_id, 2);
    chk_dat("w2_dat", m_dat, 1536'hB7B6B5B4B3B2B1B0);
    send(3'd0, 0, 1'b1, 1536'hFFFF);
    idle(); #2;
    chk("flush_nb", m_nb, 2);
    chk_dat("flush_dat", m_dat, 1536'h0908);
    send(3'd1, 5, 1'b0, 1536'hC4C3C2C1C0);
    idle(); #2;
    chk_dat("id1_dat", m_dat, 1536'hC4C3C2C1C0A2A1A0);

    @(negedge clk);
    i_rdy = 1'b0;
    send(3'd3, 8, 1'b0, 1536'hD7D6D5D4D3D2D1D0);
    fork
      begin
        send(3'd3, 8, 1'b0, 1536'hE7E6E5E4E3E2E1E0);
        send(3'd3, 4, 1'b0, 1536'hF3F2F1F0);
        send(3'd3, 0, 1'b1, 1536'h0);
      end
      begin
        repeat (3) @(negedge clk);
        #2;
        chk("stall_rdy", m_rdy, 0);
        chk_dat("stall_dat", m_dat, 1536'hD7D6D5D4D3D2D1D0);
        @(negedge clk);
        i_rdy = 1'b1;
      end
    join
    idle();
    drain();

    send(3'd0, 9, 1'b0, 1536'h1);
    idle(); #2;
    chk("err_nb9", m_err, 1);
    chk("err_nb9_vld", m_vld, 0);
    send(3'd6, 4, 1'b0, 1536'h1);
    idle(); #2;
    chk("err_id6", m_err, 1);
    send(3'd0, 0, 1'b0, 1536'h1);
    idle();

    send(3'd0, 5, 1'b0, 1536'h2423222120);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midrst_vld", m_vld, 0);
    chk("midrst_rdy", m_rdy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(3'd0, 3, 1'b0, 1536'hFFFFFFFFFF323130);
    idle(); #2;
    chk("post_rst_no_word", m_vld, 0);
    send(3'd0, 5, 1'b0, 1536'h4443424140);
    idle(); #2;
    chk("post_rst_nb", m_nb, 8);
    chk_dat("post_rst_dat", m_dat, 1536'h4443424140323130);
    drain();

    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    phase = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_rand = 1'b1;
    for (int b = 0; b < 400; b++) begin
      for (int k = 0; k < 48; k++) d[k*32 +: 32] = $urandom();
      case ($urandom_range(0, 3))
        0: n = $urandom_range(0, 192);
        1: n = $urandom_range(150, 192);
        default: n = $urandom_range(1, 80);
      endcase
      fl = ($urandom_range(0, 4) == 0) || (n == 0);
      send(3'($urandom_range(0, 5)), n, fl, d);
      if ($urandom_range(0, 5) == 0) idle();
    end
    for (int k = 0; k < 6; k++) send(3'(k), 0, 1'b1, '0);
    idle();
    rdy_rand = 1'b0;
    @(negedge clk);
    i_rdy = 1'b1;
    drain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
